// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard/forwarding bus: issue record, operand lookups and the
// resulting forward selects, stall and stall statistics.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 32
);
  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);
  localparam int unsigned RS_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                       advance;
  logic [NUM_STAGES-1:0]      flush_mask;
  logic                       issue_valid;
  logic                       issue_we;
  logic [REG_W-1:0]           issue_rd;
  logic [RS_W-1:0]            issue_ready_stage;
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC*REG_W-1:0]   src_reg;
  logic                       stat_clear;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic                       issue_accept;
  logic [CNT_W-1:0]           stall_cycles;

  modport master (
    output advance, flush_mask, issue_valid, issue_we, issue_rd,
           issue_ready_stage, src_valid, src_reg, stat_clear,
    input  fwd_sel, stall, issue_accept, stall_cycles
  );

  modport slave (
    input  advance, flush_mask, issue_valid, issue_we, issue_rd,
           issue_ready_stage, src_valid, src_reg, stat_clear,
    output fwd_sel, stall, issue_accept, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes from EX to WB; picks the youngest producer
// per source operand to forward from, or stalls decode until it is ready.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);
  localparam int unsigned RS_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [RS_W-1:0]  rdy;
  } rec_t;

  rec_t                     rec_q [NUM_STAGES];
  rec_t                     rec_d [NUM_STAGES];
  logic [CNT_W-1:0]         stall_cnt_q;
  logic [CNT_W-1:0]         stall_cnt_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic [NUM_SRC-1:0]       blocked_c;
  logic                     stall_c;
  logic                     issue_accept_c;

  // Operand lookup: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_sel_c = '0;
    blocked_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_valid[i] && (bus.src_reg[i*REG_W +: REG_W] != '0)) begin
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
          if (rec_q[s].valid && (rec_q[s].rd == bus.src_reg[i*REG_W +: REG_W])) begin
            if (s >= int'(rec_q[s].rdy)) begin
              fwd_sel_c[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
              blocked_c[i]                = 1'b0;
            end else begin
              fwd_sel_c[i*SEL_W +: SEL_W] = '0;
              blocked_c[i]                = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall_c        = bus.issue_valid && (|blocked_c);
  assign issue_accept_c = bus.advance && bus.issue_valid && !stall_c;

  // Shift on advance, insert the accepted issue (or a bubble), then flush.
  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      rec_d[s] = rec_q[s];
    end
    if (bus.advance) begin
      for (int s = 1; s < NUM_STAGES; s++) begin
        rec_d[s] = rec_q[s-1];
      end
      rec_d[0].valid = issue_accept_c && bus.issue_we && (bus.issue_rd != '0);
      rec_d[0].rd    = bus.issue_rd;
      rec_d[0].rdy   = bus.issue_ready_stage;
    end
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (bus.flush_mask[s]) begin
        rec_d[s].valid = 1'b0;
      end
    end
  end

  // Saturating stall counter; clear has priority over an increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stat_clear) begin
      stall_cnt_d = '0;
    end else if (bus.advance && stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        rec_q[s] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        rec_q[s] <= rec_d[s];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_sel      = fwd_sel_c;
  assign bus.stall        = stall_c;
  assign bus.issue_accept = issue_accept_c;
  assign bus.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use stalls, youngest
// producer selection, freeze/flush, counter saturation and reset.
module tb_hazard_scoreboard;
  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SEL_W      = $clog2(NUM_STAGES + 1);
  localparam int unsigned RS_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned SRC_BITS   = NUM_SRC * REG_W;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   exp_sc;

  hazard_scoreboard_if #(.NUM_STAGES(NUM_STAGES), .NUM_SRC(NUM_SRC),
                         .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.NUM_STAGES(NUM_STAGES), .NUM_SRC(NUM_SRC),
                      .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fsel(input int i);
    return 32'(bus.fwd_sel[i*SEL_W +: SEL_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.advance           = 1'b1;
    bus.flush_mask        = '0;
    bus.issue_valid       = 1'b0;
    bus.issue_we          = 1'b0;
    bus.issue_rd          = '0;
    bus.issue_ready_stage = '0;
    bus.src_valid         = '0;
    bus.src_reg           = '0;
    bus.stat_clear        = 1'b0;
  endtask

  task automatic issue(input logic [REG_W-1:0] rd, input logic [RS_W-1:0] rs);
    bus.issue_valid       = 1'b1;
    bus.issue_we          = 1'b1;
    bus.issue_rd          = rd;
    bus.issue_ready_stage = rs;
  endtask

  task automatic set_src(input int i, input logic [REG_W-1:0] r);
    bus.src_valid[i]               = 1'b1;
    bus.src_reg[i*REG_W +: REG_W]  = r;
  endtask

  task automatic flush_all();
    idle();
    bus.advance    = 1'b0;
    bus.flush_mask = '1;
    tick();
  endtask

  task automatic randomize_inputs();
    bus.advance           = 1'($urandom);
    bus.flush_mask        = NUM_STAGES'($urandom);
    bus.issue_valid       = 1'($urandom);
    bus.issue_we          = 1'($urandom);
    bus.issue_rd          = REG_W'($urandom);
    bus.issue_ready_stage = RS_W'($urandom);
    bus.src_valid         = NUM_SRC'($urandom);
    bus.src_reg           = SRC_BITS'($urandom);
    bus.stat_clear        = 1'($urandom);
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b0;
    randomize_inputs();
    #2;
    repeat (3) begin
      tick();
      randomize_inputs();
      #2;
      check("rst_fwd0", fsel(0), 0);
      check("rst_fwd1", fsel(1), 0);
      check("rst_stall", 32'(bus.stall), 0);
      check("rst_sc", 32'(bus.stall_cycles), 0);
      check("rst_accept", 32'(bus.issue_accept), 32'(bus.issue_valid && bus.advance));
    end
    rst = 1'b1;
    #1;
    check("rel_fwd0", fsel(0), 0);
    check("rel_fwd1", fsel(1), 0);
    check("rel_stall", 32'(bus.stall), 0);
    check("rel_sc", 32'(bus.stall_cycles), 0);
    idle();
    bus.advance    = 1'b0;
    bus.flush_mask = '1;
    bus.stat_clear = 1'b1;
    tick();

    // ALU chain
    idle();
    issue(5'd5, 2'd0);
    #2;
    check("alu_accept", 32'(bus.issue_accept), 1);
    tick();
    idle();
    set_src(0, 5'd5);
    for (int k = 1; k <= 4; k++) begin
      #2;
      check("alu_fwd0", fsel(0), (k < 4) ? 32'(k) : 32'd0);
      check("alu_stall", 32'(bus.stall), 0);
      tick();
    end

    // Load-use
    idle();
    issue(5'd7, 2'd1);
    tick();
    idle();
    bus.issue_valid = 1'b1;
    set_src(1, 5'd7);
    #2;
    check("lu_stall", 32'(bus.stall), 1);
    check("lu_accept", 32'(bus.issue_accept), 0);
    check("lu_fwd1_blk", fsel(1), 0);
    tick();
    #2;
    check("lu_fwd1", fsel(1), 2);
    check("lu_stall2", 32'(bus.stall), 0);
    check("lu_accept2", 32'(bus.issue_accept), 1);
    check("lu_sc", 32'(bus.stall_cycles), 1);
    tick();

    // Youngest producer wins
    flush_all();
    idle(); issue(5'd3, 2'd0); tick();
    idle(); tick();
    issue(5'd3, 2'd0); tick();
    idle();
    set_src(0, 5'd3);
    #2;
    check("young_fwd0", fsel(0), 1);
    check("young_stall", 32'(bus.stall), 0);

    // Youngest not ready blocks even though an older copy is ready
    flush_all();
    idle(); issue(5'd4, 2'd0); tick();
    idle(); issue(5'd4, 2'd1); tick();
    idle();
    bus.issue_valid = 1'b1;
    set_src(0, 5'd4);
    #2;
    check("young_blk_stall", 32'(bus.stall), 1);
    check("young_blk_fwd0", fsel(0), 0);

    // x0 is never forwarded
    flush_all();
    idle(); issue(5'd0, 2'd0); tick();
    idle();
    bus.issue_valid = 1'b1;
    set_src(0, 5'd0);
    #2;
    check("x0_fwd0", fsel(0), 0);
    check("x0_stall", 32'(bus.stall), 0);

    // Freeze then flush stage 0 while frozen
    flush_all();
    idle(); issue(5'd9, 2'd0); tick();
    idle();
    bus.advance     = 1'b0;
    bus.issue_valid = 1'b1;
    set_src(0, 5'd9);
    for (int k = 0; k < 4; k++) begin
      #2;
      check("frz_fwd0", fsel(0), 1);
      check("frz_accept", 32'(bus.issue_accept), 0);
      tick();
    end
    bus.flush_mask = 3'b001;
    #2;
    check("frz_fwd0_pre", fsel(0), 1);
    tick();
    bus.flush_mask = '0;
    #2;
    check("flush_fwd0", fsel(0), 0);

    // Issue killed by a simultaneous stage-0 flush
    idle();
    issue(5'd10, 2'd0);
    bus.flush_mask = 3'b001;
    tick();
    idle();
    set_src(0, 5'd10);
    #2;
    check("kill_fwd0", fsel(0), 0);

    // Counter saturation
    idle();
    bus.advance    = 1'b0;
    bus.stat_clear = 1'b1;
    tick();
    idle();
    #2;
    check("cnt_clr0", 32'(bus.stall_cycles), 0);
    exp_sc = 0;
    for (int r = 0; r < 7; r++) begin
      idle(); issue(5'd11, 2'd3); tick();
      idle();
      bus.issue_valid = 1'b1;
      set_src(0, 5'd11);
      repeat (3) begin
        #2;
        if (r == 0) check("cnt_stall", 32'(bus.stall), 1);
        tick();
        exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
      end
      if (r == 1) check("cnt_mid", 32'(bus.stall_cycles), 32'(exp_sc));
    end
    check("cnt_sat", 32'(bus.stall_cycles), 15);

    // Clear during a stalled cycle wins over the increment
    idle(); issue(5'd11, 2'd3); tick();
    idle();
    bus.issue_valid = 1'b1;
    set_src(0, 5'd11);
    bus.stat_clear  = 1'b1;
    #2;
    check("clr_stall", 32'(bus.stall), 1);
    tick();
    bus.stat_clear = 1'b0;
    #2;
    check("clr_sc", 32'(bus.stall_cycles), 0);
    tick();
    #2;
    check("clr_sc_inc", 32'(bus.stall_cycles), 1);

    // Reset mid-operation drops in-flight records at once
    flush_all();
    idle(); issue(5'd12, 2'd0); tick();
    idle();
    set_src(0, 5'd12);
    #2;
    check("mid_fwd0_pre", fsel(0), 1);
    rst = 1'b0;
    #1;
    check("mid_fwd0", fsel(0), 0);
    check("mid_sc", 32'(bus.stall_cycles), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
